// File: rtl/cue_controller.sv
// Shot-input stage: shoot-key edge detect, frame-paced aim stepping and
// power charging, and the single-cycle shot strobe for the game controller.
module cue_controller #(
  parameter int ANGLE_STEPS       = 32,
  parameter int POWER_MAX         = 15,
  parameter int AIM_RATE_FRAMES   = 2,
  parameter int POWER_RATE_FRAMES = 4
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           startOfFrame,
  input  logic                           keyShoot,
  input  logic                           keyLeft,
  input  logic                           keyRight,
  input  logic                           drawLine,
  output logic                           keyRisingEdge,
  output logic                           lineWriteEnable,
  output logic [$clog2(ANGLE_STEPS)-1:0] aimAngle,
  output logic [3:0]                     power,
  output logic [3:0]                     shotPower,
  output logic                           charging,
  output logic [2:0]                     dbg_state
);

  localparam int ANGLE_W = $clog2(ANGLE_STEPS);
  localparam logic [ANGLE_W-1:0] ANGLE_ONE  = ANGLE_W'(1);
  localparam logic [7:0]         AIM_LAST   = 8'(AIM_RATE_FRAMES - 1);
  localparam logic [7:0]         POWER_LAST = 8'(POWER_RATE_FRAMES - 1);
  localparam logic [3:0]         PMAX       = 4'(POWER_MAX);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_AIM    = 3'd1,
    S_CHARGE = 3'd2,
    S_FIRE   = 3'd3,
    S_WAIT   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           frame_cnt_q, frame_cnt_d;
  logic [ANGLE_W-1:0]   aim_q, aim_d;
  logic [3:0]           power_q, power_d;
  logic [3:0]           shot_power_q, shot_power_d;
  logic                 shoot_prev_q, shoot_prev_d;
  logic                 key_rise_q, key_rise_d;
  logic                 lwe_q, lwe_d;
  logic                 charging_q, charging_d;

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    aim_d        = aim_q;
    power_d      = power_q;
    shot_power_d = shot_power_q;
    shoot_prev_d = keyShoot;
    key_rise_d   = keyShoot & ~shoot_prev_q;

    case (state_q)
      S_IDLE: begin
        frame_cnt_d = 8'd0;
        power_d     = 4'd0;
        if (drawLine) state_d = S_AIM;
      end
      S_AIM: begin
        if (!drawLine) begin
          state_d     = S_IDLE;
          frame_cnt_d = 8'd0;
        end else if (key_rise_q) begin
          state_d     = S_CHARGE;
          power_d     = 4'd1;
          frame_cnt_d = 8'd0;
        end else if (startOfFrame) begin
          if (frame_cnt_q == AIM_LAST) begin
            frame_cnt_d = 8'd0;
            if (keyLeft && !keyRight)      aim_d = aim_q - ANGLE_ONE;
            else if (keyRight && !keyLeft) aim_d = aim_q + ANGLE_ONE;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      S_CHARGE: begin
        // A falling drawLine wins over a simultaneous release: no strobe.
        if (!drawLine) begin
          state_d     = S_IDLE;
          power_d     = 4'd0;
          frame_cnt_d = 8'd0;
        end else if (!keyShoot) begin
          state_d      = S_FIRE;
          shot_power_d = power_q;
          power_d      = 4'd0;
          frame_cnt_d  = 8'd0;
        end else if (startOfFrame) begin
          if (frame_cnt_q == POWER_LAST) begin
            frame_cnt_d = 8'd0;
            if (power_q < PMAX) power_d = power_q + 4'd1;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end
      S_FIRE: begin
        state_d     = S_WAIT;
        frame_cnt_d = 8'd0;
      end
      S_WAIT: begin
        frame_cnt_d = 8'd0;
        if (!drawLine) state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        frame_cnt_d = 8'd0;
      end
    endcase

    // Strobe and charging flag are registered copies of the next state.
    lwe_d      = (state_d == S_FIRE);
    charging_d = (state_d == S_CHARGE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= S_IDLE;
      frame_cnt_q  <= 8'd0;
      aim_q        <= '0;
      power_q      <= 4'd0;
      shot_power_q <= 4'd0;
      shoot_prev_q <= 1'b0;
      key_rise_q   <= 1'b0;
      lwe_q        <= 1'b0;
      charging_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      aim_q        <= aim_d;
      power_q      <= power_d;
      shot_power_q <= shot_power_d;
      shoot_prev_q <= shoot_prev_d;
      key_rise_q   <= key_rise_d;
      lwe_q        <= lwe_d;
      charging_q   <= charging_d;
    end
  end

  assign keyRisingEdge   = key_rise_q;
  assign lineWriteEnable = lwe_q;
  assign aimAngle        = aim_q;
  assign power           = power_q;
  assign shotPower       = shot_power_q;
  assign charging        = charging_q;
  assign dbg_state       = state_q;

endmodule

// File: doc/cue_controller.md
# cue_controller

Player shot-input stage sitting directly upstream of the game controller. Turns debounced push-button levels into the start-key rising-edge pulse, a wrap-around aim angle and a frame-paced charging power. It issues the single-cycle `lineWriteEnable` shot strobe that the game controller counts as an attempt and the ball physics consumes as a launch. Shooting is enabled only while the game controller's `drawLine` indicates that all balls are at rest and the game has started.

## Interface
Parameters:
- ANGLE_STEPS, 32: number of discrete aim directions; power of two; `aimAngle` width = log2(ANGLE_STEPS).
- POWER_MAX, 15: saturation value of power; fits in 4 bits.
- AIM_RATE_FRAMES, 2: frames per one-step aim change while a direction key is held.
- POWER_RATE_FRAMES, 4: frames per +1 power step while charging.

Ports:
- clk  in  1  system clock; one clock domain.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse per video frame.
- keyShoot  in  1  debounced shoot/start key level, active high.
- keyLeft  in  1  debounced rotate-counter-clockwise key level.
- keyRight  in  1  debounced rotate-clockwise key level.
- drawLine  in  1  from game controller; high = shot allowed.
- keyRisingEdge  out  1  one-cycle pulse on each keyShoot rising edge; goes to the game controller.
- lineWriteEnable  out  1  one-cycle shot strobe; goes to the game controller and ball physics.
- aimAngle  out  log2(ANGLE_STEPS)  current aim direction index.
- power  out  4  live charging power; 0 when not charging.
- shotPower  out  4  power latched at the last shot.
- charging  out  1  high while in CHARGE; drives the cue-pull graphic.

## Operation
- Edge detect:
  - `shootPrev <= keyShoot`; `keyRisingEdge <= keyShoot & ~shootPrev`.
  - Runs in every state, including IDLE, so the game controller can use it to start the game.
- FSM states: IDLE, AIM, CHARGE, FIRE, WAIT.
  - IDLE: when `drawLine` is 1, go to AIM. Clear the frame counter.
  - AIM:
    - Count startOfFrame pulses. When the count reaches AIM_RATE_FRAMES, clear it and step the angle.
    - keyLeft only: `aimAngle - 1`, mod ANGLE_STEPS.
    - keyRight only: `aimAngle + 1`, mod ANGLE_STEPS.
    - Both keys or neither: hold the angle.
    - On `keyRisingEdge`: go to CHARGE, set `power = 1`, clear the frame counter.
    - If `drawLine` is 0: go to IDLE.
  - CHARGE:
    - `charging = 1`. `aimAngle` is frozen.
    - Every POWER_RATE_FRAMES frames, `power + 1`, saturating at POWER_MAX.
    - If `keyShoot` is 0: go to FIRE.
    - If `drawLine` falls first: abort to IDLE with `power = 0`. No strobe is issued.
  - FIRE: exactly one cycle.
    - `lineWriteEnable = 1`, `shotPower <= power`, `power <= 0`.
    - Go to WAIT.
  - WAIT: stay until `drawLine` is 0 (balls moving), then go to IDLE. A shot cannot repeat until the balls stop again.
- `aimAngle` persists across shots and IDLE. Only reset clears it.
- `shotPower` holds its value until the next FIRE.

## Timing
- Reset values:
  - State IDLE.
  - `keyRisingEdge`, `lineWriteEnable`, `charging` = 0.
  - `aimAngle`, `power`, `shotPower` = 0.
  - `shootPrev` and the frame counter = 0.
- All outputs are registered.
- `keyRisingEdge` is high in the cycle after the first clock edge that samples `keyShoot = 1`.
- CHARGE is entered the cycle after the `keyRisingEdge` pulse. The same edge that started the game may begin a charge only if `drawLine` is already high.
- `lineWriteEnable` asserts in the cycle after the edge that samples `keyShoot = 0` in CHARGE. Pulse width is always 1.
- A key release in the same cycle that `drawLine` falls takes the abort path: IDLE, no strobe.
- Angle and power steps happen in the cycle after the qualifying startOfFrame. Frame counters are cleared on every state entry.
- Asserting resetN low mid-CHARGE or mid-FIRE clears outputs immediately (asynchronous reset), with no strobe.

## Test plan
- Reset, then `keyShoot` held high for 10 cycles with `drawLine = 0` → exactly one `keyRisingEdge` pulse, state stays IDLE, `lineWriteEnable` never high.
- `drawLine = 1`, `keyRight` held for 8 frames at AIM_RATE_FRAMES = 2 → `aimAngle = 4`. Then `keyLeft` held for 12 frames → angle 4 → 30 (wraps through 0).
- Press shoot, hold 80 frames, release → `power` reaches 15 and holds. One `lineWriteEnable` pulse. `shotPower = 15`, `power = 0`, `charging` = 0.
- Press and release within 3 frames → `shotPower = 1`. With `drawLine` held at 1 after the shot, state stays WAIT and a second press gives no strobe. After `drawLine` pulses 0 then 1, a new shot is accepted.
- Mid-CHARGE (`power = 6`), drop `drawLine` → `charging = 0`, `power = 0`, no strobe, `shotPower` unchanged.
- Pulse resetN low during CHARGE → all outputs are 0 in the same cycle. After release, the state is IDLE.
